int_ctrl: RTL and testbench

- Interrupt controller that feeds the CPU control unit and the vector/stack path.
- Latches four external interrupt lines, applies a mask and a global enable, and selects one winner by fixed priority.
- Raises a request, presents the winner's 10-bit vector, and tracks in-service state until the CPU executes an interrupt return.
- The CPU acknowledges a request on the cycle it pushes the PC onto the return stack.

---
 rtl/int_ctrl_if.sv | 26 ++
 rtl/int_ctrl.sv | 149 ++++++++++++++
 tb/tb_int_ctrl.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/int_ctrl_if.sv
// CPU-side bus of the interrupt controller: enable, mask access, request/ack handshake
// and status readback.
interface int_ctrl_if #(
    parameter int VEC_W = 10
);
    logic             int_en;
    logic             mask_we;
    logic [3:0]       mask_d;
    logic             int_ack;
    logic             iret;
    logic             int_req;
    logic [VEC_W-1:0] vector;
    logic [3:0]       pending;
    logic [3:0]       in_service;
    logic [3:0]       mask_q;

    modport master (
        output int_en, mask_we, mask_d, int_ack, iret,
        input  int_req, vector, pending, in_service, mask_q
    );

    modport slave (
        input  int_en, mask_we, mask_d, int_ack, iret,
        output int_req, vector, pending, in_service, mask_q
    );
endinterface

// File: rtl/int_ctrl.sv
// Four-line edge-triggered interrupt controller with fixed priority, a mask and
// single-level in-service tracking.
module int_ctrl #(
    parameter int               VEC_W = 10,
    parameter logic [VEC_W-1:0] VEC0  = 10'b1111111011,
    parameter logic [VEC_W-1:0] VEC1  = 10'b1111111110,
    parameter logic [VEC_W-1:0] VEC2  = 10'b1111111101,
    parameter logic [VEC_W-1:0] VEC3  = 10'b1111111100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  irq_in,
    int_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        SERV = 2'd2
    } state_t;

    state_t           state_r, state_next_s;
    logic [3:0]       sync1_r, sync2_r, sync3_r;
    logic [3:0]       pending_r, in_service_r, mask_r;
    logic [1:0]       winner_r, winner_next_s, prio_idx_s;
    logic             int_req_r, int_req_next_s;
    logic [VEC_W-1:0] vector_r, vector_next_s;
    logic [3:0]       in_service_next_s, clear_s, edge_s, eligible_s;

    // Lowest index wins; caller guarantees at least one bit is set.
    function automatic logic [1:0] prio_enc(input logic [3:0] req);
        logic [1:0] idx;
        if (req[0]) begin
            idx = 2'd0;
        end else if (req[1]) begin
            idx = 2'd1;
        end else if (req[2]) begin
            idx = 2'd2;
        end else begin
            idx = 2'd3;
        end
        return idx;
    endfunction

    function automatic logic [VEC_W-1:0] vec_of(input logic [1:0] idx);
        logic [VEC_W-1:0] v;
        case (idx)
            2'd0:    v = VEC0;
            2'd1:    v = VEC1;
            2'd2:    v = VEC2;
            2'd3:    v = VEC3;
            default: v = VEC3;
        endcase
        return v;
    endfunction

    assign edge_s     = sync2_r & ~sync3_r;
    assign eligible_s = pending_r & mask_r;
    assign prio_idx_s = prio_enc(eligible_s);

    // Two-flop synchroniser plus one flop of history for rising-edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_r <= 4'b0000;
            sync2_r <= 4'b0000;
            sync3_r <= 4'b0000;
        end else begin
            sync1_r <= irq_in;
            sync2_r <= sync1_r;
            sync3_r <= sync2_r;
        end
    end

    // Next-state and next-output decode; the winner is frozen once REQ is entered.
    always_comb begin
        state_next_s      = state_r;
        winner_next_s     = winner_r;
        clear_s           = 4'b0000;
        in_service_next_s = in_service_r;
        int_req_next_s    = 1'b0;
        vector_next_s     = vector_r;
        case (state_r)
            IDLE: begin
                if (bus.int_en && (eligible_s != 4'b0000)) begin
                    state_next_s   = REQ;
                    winner_next_s  = prio_idx_s;
                    int_req_next_s = 1'b1;
                    vector_next_s  = vec_of(prio_idx_s);
                end else begin
                    vector_next_s  = {VEC_W{1'b0}};
                end
            end
            REQ: begin
                if (bus.int_ack) begin
                    state_next_s      = SERV;
                    clear_s           = 4'b0001 << winner_r;
                    in_service_next_s = 4'b0001 << winner_r;
                end else if (!bus.int_en) begin
                    state_next_s  = IDLE;
                    vector_next_s = {VEC_W{1'b0}};
                end else begin
                    int_req_next_s = 1'b1;
                end
            end
            SERV: begin
                if (bus.iret) begin
                    state_next_s      = IDLE;
                    in_service_next_s = 4'b0000;
                    vector_next_s     = {VEC_W{1'b0}};
                end else begin
                    state_next_s = SERV;
                end
            end
            default: begin
                state_next_s      = IDLE;
                in_service_next_s = 4'b0000;
                vector_next_s     = {VEC_W{1'b0}};
            end
        endcase
    end

    // Control state, pending latch (a fresh edge beats the ack clear), mask and outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= IDLE;
            winner_r     <= 2'd0;
            pending_r    <= 4'b0000;
            in_service_r <= 4'b0000;
            mask_r       <= 4'b0000;
            int_req_r    <= 1'b0;
            vector_r     <= {VEC_W{1'b0}};
        end else begin
            state_r      <= state_next_s;
            winner_r     <= winner_next_s;
            pending_r    <= (pending_r & ~clear_s) | edge_s;
            in_service_r <= in_service_next_s;
            mask_r       <= bus.mask_we ? bus.mask_d : mask_r;
            int_req_r    <= int_req_next_s;
            vector_r     <= vector_next_s;
        end
    end

    assign bus.int_req    = int_req_r;
    assign bus.vector     = vector_r;
    assign bus.pending    = pending_r;
    assign bus.in_service = in_service_r;
    assign bus.mask_q     = mask_r;

endmodule

// File: tb/tb_int_ctrl.sv
// Bench for int_ctrl: directed scenarios then random traffic, checked against an
// event-level model with a scoreboard of expected request vectors.
module tb_int_ctrl;

    localparam int VEC_W = 10;
    localparam logic [9:0] V0 = 10'b1111111011;
    localparam logic [9:0] V1 = 10'b1111111110;
    localparam logic [9:0] V2 = 10'b1111111101;
    localparam logic [9:0] V3 = 10'b1111111100;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] irq_in;

    int_ctrl_if #(.VEC_W(VEC_W)) bus ();

    int_ctrl dut (
        .clk    (clk),
        .reset  (reset),
        .irq_in (irq_in),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Reference model: which line is requesting / being served, pending set, mask,
    // and a short history of irq samples. Edges latch two clocks after first sample.
    logic [9:0] vec_tab [4];
    initial begin
        vec_tab[0] = V0; vec_tab[1] = V1; vec_tab[2] = V2; vec_tab[3] = V3;
    end

    int         m_req, m_serv;
    logic [3:0] m_pend, m_mask;
    logic [3:0] hist [3];
    logic [9:0] sb_q [$];

    function automatic int lowest(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return -1;
    endfunction

    always @(posedge clk or negedge reset) begin
        logic [3:0] rise, elig;
        if (!reset) begin
            m_req = -1; m_serv = -1; m_pend = 4'b0000; m_mask = 4'b0000;
            for (int i = 0; i < 3; i++) hist[i] = 4'b0000;
            sb_q.delete();
        end else begin
            rise = hist[1] & ~hist[2];
            elig = m_pend & m_mask;
            if (m_serv >= 0) begin
                if (bus.iret) m_serv = -1;
            end else if (m_req >= 0) begin
                if (bus.int_ack) begin
                    m_serv = m_req;
                    m_pend[m_req] = 1'b0;
                    m_req = -1;
                end else if (!bus.int_en) begin
                    m_req = -1;
                end
            end else if (bus.int_en && elig != 4'b0000) begin
                m_req = lowest(elig);
                sb_q.push_back(vec_tab[m_req]);
            end
            m_pend = m_pend | rise;
            if (bus.mask_we) m_mask = bus.mask_d;
            hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = irq_in;
        end
    end

    // Monitor: compare visible state every cycle; pop the scoreboard on each new request.
    logic prev_req = 1'b0;
    always @(negedge clk) begin
        logic [9:0] exp_vec, got;
        if (reset) begin
            exp_vec = (m_req >= 0) ? vec_tab[m_req] : ((m_serv >= 0) ? vec_tab[m_serv] : 10'd0);
            chk("pending", 32'(bus.pending), 32'(m_pend));
            chk("mask_q", 32'(bus.mask_q), 32'(m_mask));
            chk("in_service", 32'(bus.in_service), (m_serv >= 0) ? (32'd1 << m_serv) : 32'd0);
            chk("int_req", 32'(bus.int_req), (m_req >= 0) ? 32'd1 : 32'd0);
            chk("vector", 32'(bus.vector), 32'(exp_vec));
            if (bus.int_req && !prev_req) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_req", 32'(bus.vector), 32'hFFFF_FFFF);
                end else begin
                    got = sb_q.pop_front();
                    chk("req_vector", 32'(bus.vector), 32'(got));
                end
            end
            prev_req = bus.int_req;
        end else begin
            prev_req = 1'b0;
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_pending"}, 32'(bus.pending), 32'd0);
        chk({tag, "_in_service"}, 32'(bus.in_service), 32'd0);
        chk({tag, "_mask_q"}, 32'(bus.mask_q), 32'd0);
        chk({tag, "_int_req"}, 32'(bus.int_req), 32'd0);
        chk({tag, "_vector"}, 32'(bus.vector), 32'd0);
    endtask

    initial begin
        int w;
        reset = 1'b0; irq_in = 4'b0000;
        bus.int_en = 1'b0; bus.int_ack = 1'b0; bus.iret = 1'b0;
        bus.mask_we = 1'b0; bus.mask_d = 4'b0000;
        tick(2);
        chk_all_zero("reset");
        reset = 1'b1;
        tick(1);
        bus.mask_we = 1'b1; bus.mask_d = 4'b1111;
        tick(1);
        bus.mask_we = 1'b0;
        chk("t1_mask", 32'(bus.mask_q), 32'hF);

        // Basic service of line 2
        bus.int_en = 1'b1; irq_in = 4'b0100;
        tick(2);
        chk("t1_pend_early", 32'(bus.pending), 32'd0);
        tick(1);
        chk("t1_pend", 32'(bus.pending), 32'b0100);
        chk("t1_noreq", 32'(bus.int_req), 32'd0);
        tick(1);
        chk("t1_req", 32'(bus.int_req), 32'd1);
        chk("t1_vec", 32'(bus.vector), 32'(V2));
        bus.int_ack = 1'b1;
        tick(1);
        bus.int_ack = 1'b0;
        chk("t1_insvc", 32'(bus.in_service), 32'b0100);
        chk("t1_pend_clr", 32'(bus.pending), 32'd0);
        chk("t1_req_drop", 32'(bus.int_req), 32'd0);
        chk("t1_vec_hold", 32'(bus.vector), 32'(V2));
        bus.iret = 1'b1;
        tick(1);
        bus.iret = 1'b0; irq_in = 4'b0000;
        chk("t1_iret", 32'(bus.in_service), 32'd0);

        // Priority: lines 3 and 1 together
        irq_in = 4'b1010;
        tick(4);
        chk("t2_pend", 32'(bus.pending), 32'b1010);
        chk("t2_vec1", 32'(bus.vector), 32'(V1));
        bus.int_ack = 1'b1;
        tick(1);
        bus.int_ack = 1'b0; bus.iret = 1'b1;
        tick(1);
        bus.iret = 1'b0;
        chk("t2_idle_gap", 32'(bus.int_req), 32'd0);
        tick(1);
        chk("t2_req3", 32'(bus.int_req), 32'd1);
        chk("t2_vec3", 32'(bus.vector), 32'(V3));
        bus.int_ack = 1'b1;
        tick(1);
        bus.int_ack = 1'b0; bus.iret = 1'b1;
        tick(1);
        bus.iret = 1'b0; irq_in = 4'b0000;

        // Masking of line 0
        bus.mask_we = 1'b1; bus.mask_d = 4'b1110; irq_in = 4'b0001;
        tick(1);
        bus.mask_we = 1'b0;
        tick(4);
        chk("t3_pend", 32'(bus.pending), 32'b0001);
        chk("t3_masked", 32'(bus.int_req), 32'd0);
        bus.mask_we = 1'b1; bus.mask_d = 4'b1111;
        tick(1);
        bus.mask_we = 1'b0;
        tick(1);
        chk("t3_req", 32'(bus.int_req), 32'd1);
        chk("t3_vec", 32'(bus.vector), 32'(V0));

        // Enable withdrawal in REQ, then no nesting in SERV
        bus.int_en = 1'b0;
        tick(1);
        chk("t4_withdraw", 32'(bus.int_req), 32'd0);
        chk("t4_pend_kept", 32'(bus.pending), 32'b0001);
        bus.int_en = 1'b1;
        tick(1);
        chk("t4_rereq", 32'(bus.int_req), 32'd1);
        bus.int_ack = 1'b1;
        tick(1);
        bus.int_ack = 1'b0; irq_in = 4'b0000;
        tick(1);
        irq_in = 4'b0001;
        tick(3);
        chk("t4_pend_serv", 32'(bus.pending), 32'b0001);
        chk("t4_nonest", 32'(bus.int_req), 32'd0);
        tick(2);
        bus.iret = 1'b1;
        tick(1);
        bus.iret = 1'b0;
        chk("t4_gap", 32'(bus.int_req), 32'd0);
        tick(1);
        chk("t4_req_after", 32'(bus.int_req), 32'd1);

        // New edge on the winner line lands in the ack cycle
        irq_in = 4'b0000;
        tick(1);
        irq_in = 4'b0001;
        tick(2);
        bus.int_ack = 1'b1;
        tick(1);
        bus.int_ack = 1'b0;
        chk("t5_insvc", 32'(bus.in_service), 32'b0001);
        chk("t5_pend_set", 32'(bus.pending), 32'b0001);
        bus.iret = 1'b1;
        tick(1);
        bus.iret = 1'b0;
        tick(1);
        chk("t5_again", 32'(bus.vector), 32'(V0));
        bus.int_ack = 1'b1;
        tick(1);
        bus.int_ack = 1'b0; bus.iret = 1'b1;
        tick(1);
        bus.iret = 1'b0; irq_in = 4'b0000;

        // Async reset while in service
        irq_in = 4'b0100;
        w = 0;
        while (!bus.int_req && w < 10) begin
            tick(1);
            w++;
        end
        chk("t6_req", 32'(bus.int_req), 32'd1);
        bus.int_ack = 1'b1;
        tick(1);
        bus.int_ack = 1'b0;
        chk("t6_serv", 32'(bus.in_service), 32'b0100);
        #2 reset = 1'b0;
        #1 chk_all_zero("t6");
        tick(1);
        reset = 1'b1;

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 4; i++)
                if ($urandom_range(0, 7) == 0) irq_in[i] = ~irq_in[i];
            bus.int_en  = ($urandom_range(0, 15) != 0);
            bus.int_ack = bus.int_req ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 15) == 0);
            bus.iret    = (bus.in_service != 4'b0000) ? ($urandom_range(0, 3) == 0)
                                                      : ($urandom_range(0, 15) == 0);
            bus.mask_we = ($urandom_range(0, 15) == 0);
            bus.mask_d  = 4'($urandom_range(0, 15));
            tick(1);
        end
        bus.int_ack = 1'b0; bus.iret = 1'b0; bus.mask_we = 1'b0;
        tick(5);
        #1 chk("sb_drain", 32'(sb_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
